mem_port_arbiter: RTL

//  Shares one memory port between two pulse-based masters: M0 = simple_cpu, M1 = loader/debug.

---
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus interfaces for mem_port_arbiter: the pulse-based CPU memory protocol seen by each
// master, and the single shared memory port driven by the arbiter.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              read_req;
    logic [ADDR_W-1:0] read_addr;
    logic [DATA_W-1:0] read_data;
    logic              read_data_valid;
    logic              write_req;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;
    logic [3:0]        memory_mask;

    modport master (
        output read_req, read_addr, write_req, write_addr, write_data, memory_mask,
        input  read_data, read_data_valid
    );

    modport slave (
        input  read_req, read_addr, write_req, write_addr, write_data, memory_mask,
        output read_data, read_data_valid
    );
endinterface

interface mem_port_arbiter_mem_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              read_req;
    logic              write_req;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] write_data;
    logic [3:0]        memory_mask;
    logic [DATA_W-1:0] read_data;
    logic              read_data_valid;

    modport master (
        output read_req, write_req, addr, write_data, memory_mask,
        input  read_data, read_data_valid
    );

    modport slave (
        input  read_req, write_req, addr, write_data, memory_mask,
        output read_data, read_data_valid
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-master round-robin arbiter for one memory port with per-master 2-entry queues and a
// single outstanding read. Optional read timeout: define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    mem_port_arbiter_if.slave      m0,
    mem_port_arbiter_if.slave      m1,
    mem_port_arbiter_mem_if.master mem,
    output logic [1:0]             overflow_err,
    output logic                   timeout_err
);
    localparam int unsigned NM    = 2;
    localparam int unsigned QD    = 2;
    localparam int unsigned CNT_W = 2;
    localparam logic [CNT_W-1:0] Q_FULL       = CNT_W'(QD);
    localparam logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(32'hDEADBEEF);

    typedef enum logic {S_IDLE, S_RD_WAIT} state_t;

    typedef struct packed {
        logic              is_wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [3:0]        mask;
    } entry_t;

    state_t            state, state_n;
    entry_t            q     [NM][QD];
    entry_t            q_n   [NM][QD];
    logic [CNT_W-1:0]  cnt   [NM];
    logic [CNT_W-1:0]  cnt_n [NM];
    logic [NM-1:0]     rd_pend, rd_pend_n;
    logic [NM-1:0]     ovf_set;
    logic [NM-1:0]     nonempty;
    logic              rr, rr_n;
    logic              owner, owner_n;
    logic              grant_vld, grant_sel, rd_done, tmo_hit;
    entry_t            head;

    logic              mem_rd_req_q, mem_rd_req_n;
    logic              mem_wr_req_q, mem_wr_req_n;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_n;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_n;
    logic [3:0]        mem_mask_q, mem_mask_n;
    logic [DATA_W-1:0] rdata_q [NM];
    logic [DATA_W-1:0] rdata_n [NM];
    logic [NM-1:0]     rvalid_q, rvalid_n;
    logic              tmo_err_q, tmo_err_n;

    // Master-side inputs flattened into arrays so queue logic is written once
    logic [NM-1:0]     rd_req_in, wr_req_in;
    logic [ADDR_W-1:0] rd_addr_in [NM];
    logic [ADDR_W-1:0] wr_addr_in [NM];
    logic [DATA_W-1:0] wr_data_in [NM];
    logic [3:0]        mask_in    [NM];

    assign rd_req_in     = {m1.read_req, m0.read_req};
    assign wr_req_in     = {m1.write_req, m0.write_req};
    assign rd_addr_in[0] = m0.read_addr;
    assign rd_addr_in[1] = m1.read_addr;
    assign wr_addr_in[0] = m0.write_addr;
    assign wr_addr_in[1] = m1.write_addr;
    assign wr_data_in[0] = m0.write_data;
    assign wr_data_in[1] = m1.write_data;
    assign mask_in[0]    = m0.memory_mask;
    assign mask_in[1]    = m1.memory_mask;

    assign nonempty[0] = (cnt[0] != '0);
    assign nonempty[1] = (cnt[1] != '0);
    // rr names the favoured master; it only matters when both queues hold work
    assign grant_sel   = (&nonempty) ? rr : nonempty[1];
    assign grant_vld   = (state == S_IDLE) && (|nonempty);
    assign head        = q[grant_sel][0];
    assign rd_done     = (state == S_RD_WAIT) && (mem.read_data_valid || tmo_hit);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                    $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_cnt;

    assign tmo_hit = (state == S_RD_WAIT) && !mem.read_data_valid && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin : tmo_counter
        if (reset || state != S_RD_WAIT) tmo_cnt <= '0;
        else                             tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin : state_reg
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin : next_state_c
        state_n = state;
        case (state)
            S_IDLE:    if (grant_vld && !head.is_wr) state_n = S_RD_WAIT;
            S_RD_WAIT: if (rd_done)                  state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    always_comb begin : output_c
        mem_rd_req_n = 1'b0;
        mem_wr_req_n = 1'b0;
        mem_addr_n   = mem_addr_q;
        mem_wdata_n  = mem_wdata_q;
        mem_mask_n   = mem_mask_q;
        rdata_n      = rdata_q;
        rvalid_n     = '0;
        owner_n      = owner;
        rr_n         = rr;
        tmo_err_n    = tmo_err_q;
        case (state)
            S_IDLE: begin
                if (grant_vld) begin
                    mem_addr_n = head.addr;
                    mem_mask_n = head.mask;
                    rr_n       = ~grant_sel;
                    if (head.is_wr) begin
                        mem_wr_req_n = 1'b1;
                        mem_wdata_n  = head.wdata;
                    end else begin
                        mem_rd_req_n = 1'b1;
                        owner_n      = grant_sel;
                    end
                end
            end
            S_RD_WAIT: begin
                if (rd_done) begin
                    rvalid_n[owner] = 1'b1;
                    rdata_n[owner]  = mem.read_data_valid ? mem.read_data : TIMEOUT_DATA;
                    if (tmo_hit) tmo_err_n = 1'b1;
                end else begin
                    mem_rd_req_n = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Pop frees a slot before this edge's pushes; write is pushed ahead of a same-edge read
    always_comb begin : queue_c
        q_n       = q;
        cnt_n     = cnt;
        rd_pend_n = rd_pend;
        ovf_set   = '0;
        for (int i = 0; i < NM; i++) begin
            if (grant_vld && grant_sel == 1'(i)) begin
                q_n[i][0] = q[i][1];
                cnt_n[i]  = cnt[i] - 1'b1;
            end
            if (rd_done && owner == 1'(i)) rd_pend_n[i] = 1'b0;
            if (wr_req_in[i]) begin
                if (cnt_n[i] < Q_FULL) begin
                    q_n[i][cnt_n[i][0]] = '{is_wr: 1'b1, addr: wr_addr_in[i],
                                            wdata: wr_data_in[i], mask: mask_in[i]};
                    cnt_n[i] = cnt_n[i] + 1'b1;
                end else begin
                    ovf_set[i] = 1'b1;
                end
            end
            if (rd_req_in[i] && !rd_pend[i]) begin
                if (cnt_n[i] < Q_FULL) begin
                    q_n[i][cnt_n[i][0]] = '{is_wr: 1'b0, addr: rd_addr_in[i],
                                            wdata: '0, mask: mask_in[i]};
                    cnt_n[i]     = cnt_n[i] + 1'b1;
                    rd_pend_n[i] = 1'b1;
                end else begin
                    ovf_set[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin : data_regs
        if (reset) begin
            for (int i = 0; i < NM; i++) begin
                q[i][0]    <= '0;
                q[i][1]    <= '0;
                cnt[i]     <= '0;
                rdata_q[i] <= '0;
            end
            rd_pend      <= '0;
            rr           <= 1'b0;
            owner        <= 1'b0;
            mem_rd_req_q <= 1'b0;
            mem_wr_req_q <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_mask_q   <= '0;
            rvalid_q     <= '0;
            overflow_err <= '0;
            tmo_err_q    <= 1'b0;
        end else begin
            q            <= q_n;
            cnt          <= cnt_n;
            rdata_q      <= rdata_n;
            rd_pend      <= rd_pend_n;
            rr           <= rr_n;
            owner        <= owner_n;
            mem_rd_req_q <= mem_rd_req_n;
            mem_wr_req_q <= mem_wr_req_n;
            mem_addr_q   <= mem_addr_n;
            mem_wdata_q  <= mem_wdata_n;
            mem_mask_q   <= mem_mask_n;
            rvalid_q     <= rvalid_n;
            overflow_err <= overflow_err | ovf_set;
            tmo_err_q    <= tmo_err_n;
        end
    end

    assign mem.read_req        = mem_rd_req_q;
    assign mem.write_req       = mem_wr_req_q;
    assign mem.addr            = mem_addr_q;
    assign mem.write_data      = mem_wdata_q;
    assign mem.memory_mask     = mem_mask_q;
    assign m0.read_data        = rdata_q[0];
    assign m1.read_data        = rdata_q[1];
    assign m0.read_data_valid  = rvalid_q[0];
    assign m1.read_data_valid  = rvalid_q[1];
    assign timeout_err         = tmo_err_q;

endmodule
